alu: RTL and testbench



---
 rtl/alu.sv | 141 ++++++++++++++
 tb/tb_alu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered N-bit ALU with zero/overflow/carry/negative flags.
// Define ALU_MULDIV_EN to build the MUL/DIV/MOD opcodes; otherwise they act as reserved.
module alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   sel,
  output logic [N-1:0] out,
  output logic         Z,
  output logic         O,
  output logic         Ca,
  output logic         Neg
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_MUL = 4'b1000,
    OP_DIV = 4'b1001,
    OP_MOD = 4'b1010
  } op_e;

  logic [N-1:0] out_d, out_q;
  logic         z_d, z_q;
  logic         o_d, o_q;
  logic         ca_d, ca_q;
  logic         neg_d, neg_q;

  logic [N:0] sum_w;
  logic [N:0] diff_w;
  logic [N:0] shl_w;
  logic [N:0] shr_w;
  logic       shift_big;

  assign sum_w     = {1'b0, A} + {1'b0, B};
  assign diff_w    = {1'b0, A} - {1'b0, B};
  // One guard bit on each side catches the last bit shifted out.
  assign shl_w     = {1'b0, A} << B;
  assign shr_w     = {A, 1'b0} >> B;
  assign shift_big = ({1'b0, B} >= (N+1)'(N));

`ifdef ALU_MULDIV_EN
  logic [2*N-1:0] prod_w;
  logic [N-1:0]   quot_w;
  logic [N-1:0]   rem_w;
  logic           div_zero;

  assign prod_w   = {{N{1'b0}}, A} * {{N{1'b0}}, B};
  assign div_zero = (B == '0);
  assign quot_w   = div_zero ? '1 : A / B;
  assign rem_w    = div_zero ? '1 : A % B;
`endif

  always_comb begin
    out_d = '0;
    o_d   = 1'b0;
    ca_d  = 1'b0;
    case (sel)
      OP_ADD: begin
        out_d = sum_w[N-1:0];
        ca_d  = sum_w[N];
        o_d   = (A[N-1] == B[N-1]) && (sum_w[N-1] != A[N-1]);
      end
      OP_SUB: begin
        out_d = diff_w[N-1:0];
        ca_d  = diff_w[N];
        o_d   = (A[N-1] != B[N-1]) && (diff_w[N-1] != A[N-1]);
      end
      OP_AND: out_d = A & B;
      OP_OR:  out_d = A | B;
      OP_XOR: out_d = A ^ B;
      OP_NOT: out_d = ~A;
      OP_SHL: begin
        if (!shift_big) begin
          out_d = shl_w[N-1:0];
          ca_d  = shl_w[N];
        end
      end
      OP_SHR: begin
        if (!shift_big) begin
          out_d = shr_w[N:1];
          ca_d  = shr_w[0];
        end
      end
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        out_d = prod_w[N-1:0];
        o_d   = (prod_w[2*N-1:N] != '0);
      end
      OP_DIV: begin
        out_d = quot_w;
        o_d   = div_zero;
      end
      OP_MOD: begin
        out_d = rem_w;
        o_d   = div_zero;
      end
`endif
      default: begin
        out_d = '0;
        o_d   = 1'b0;
        ca_d  = 1'b0;
      end
    endcase
    z_d   = (out_d == '0);
    neg_d = out_d[N-1];
  end

  // Reset clears every flag, including Z, so outputs read all-zero until the first capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      z_q   <= 1'b0;
      o_q   <= 1'b0;
      ca_q  <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      out_q <= out_d;
      z_q   <= z_d;
      o_q   <= o_d;
      ca_q  <= ca_d;
      neg_q <= neg_d;
    end
  end

  assign out = out_q;
  assign Z   = z_q;
  assign O   = o_q;
  assign Ca  = ca_q;
  assign Neg = neg_q;

endmodule

// File: tb/tb_alu.sv
// Randomised self-checking bench for alu (N = 4) against an arithmetic reference model.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic [3:0] sel;
  logic [3:0] out;
  logic       Z, O, Ca, Neg;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  typedef struct packed {
    logic [3:0] r;
    logic       z;
    logic       o;
    logic       ca;
    logic       neg;
  } res_t;

  res_t exp_q;

  alu #(.N(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel),
    .out(out), .Z(Z), .O(O), .Ca(Ca), .Neg(Neg)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic res_t model(input int a, input int b, input int op);
    res_t m;
    int   r, sa, sb, s, p;
    bit   o, ca;
    r  = 0;
    o  = 1'b0;
    ca = 1'b0;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    case (op)
      0: begin
        s  = a + b;
        r  = s % 16;
        ca = (s > 15);
        o  = (sa + sb > 7) || (sa + sb < -8);
      end
      1: begin
        r  = (a - b + 16) % 16;
        ca = (a < b);
        o  = (sa - sb > 7) || (sa - sb < -8);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin
        if (b < 4) begin
          p = a * (1 << b);
          r = p % 16;
          if (b != 0) ca = ((p / 16) % 2) == 1;
        end
      end
      7: begin
        if (b < 4) begin
          r = a / (1 << b);
          if (b != 0) ca = ((a / (1 << (b - 1))) % 2) == 1;
        end
      end
`ifdef ALU_MULDIV_EN
      8: begin
        p = a * b;
        r = p % 16;
        o = (p > 15);
      end
      9: begin
        if (b == 0) begin r = 15; o = 1'b1; end
        else r = a / b;
      end
      10: begin
        if (b == 0) begin r = 15; o = 1'b1; end
        else r = a % b;
      end
`endif
      default: r = 0;
    endcase
    m.r   = r[3:0];
    m.z   = (r == 0);
    m.o   = o;
    m.ca  = ca;
    m.neg = (r >= 8);
    return m;
  endfunction

  // Expected outputs advance on the same events that update the DUT registers.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q = '0;
    else     exp_q = model(int'(A), int'(B), int'(sel));
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({out, Z, O, Ca, Neg} !== exp_q) begin
        failures++;
        $display("[TB] FAIL model_cmp t=%0t got out=%b Z=%b O=%b Ca=%b Neg=%b want out=%b Z=%b O=%b Ca=%b Neg=%b",
                 $time, out, Z, O, Ca, Neg, exp_q.r, exp_q.z, exp_q.o, exp_q.ca, exp_q.neg);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    @(negedge clk);
    #1;
    A   = a;
    B   = b;
    sel = s;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_out,
                             input logic e_z, input logic e_o, input logic e_ca, input logic e_neg);
    checks++;
    if ({out, Z, O, Ca, Neg} !== {e_out, e_z, e_o, e_ca, e_neg}) begin
      failures++;
      $display("[TB] FAIL %s got out=%b Z=%b O=%b Ca=%b Neg=%b want out=%b Z=%b O=%b Ca=%b Neg=%b",
               name, out, Z, O, Ca, Neg, e_out, e_z, e_o, e_ca, e_neg);
    end
  endtask

  task automatic checkModel(input string name, input res_t got, input res_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s model=%b want=%b", name, got, want);
    end
  endtask

  task automatic runOp(input string name, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                       input logic [3:0] e_out, input logic e_z, input logic e_o,
                       input logic e_ca, input logic e_neg);
    applyStimulus(a, b, s);
    @(posedge clk);
    #1;
    checkOutput(name, e_out, e_z, e_o, e_ca, e_neg);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    A   = 4'd0;
    B   = 4'd0;
    sel = 4'd0;

    checkModel("model_add_ovf", model(7, 2, 0), {4'b1001, 1'b0, 1'b1, 1'b0, 1'b1});
    checkModel("model_sub_borrow", model(3, 13, 1), {4'b0110, 1'b0, 1'b0, 1'b1, 1'b0});
    checkModel("model_shl_carry", model(9, 1, 6), {4'b0010, 1'b0, 1'b0, 1'b1, 1'b0});

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_en = 1'b1;
    rst      = 1'b0;

    runOp("add_wrap",    4'b0011, 4'b1101, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    runOp("add_carry",   4'b0111, 4'b1101, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    runOp("add_ovf",     4'b0111, 4'b0010, 4'b0000, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);
    runOp("sub_borrow",  4'b0011, 4'b1101, 4'b0001, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    runOp("sub_plain",   4'b0111, 4'b0010, 4'b0001, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp("and_neg",     4'b1010, 4'b1010, 4'b0010, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
    runOp("or_all",      4'b0000, 4'b1111, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    runOp("and_one",     4'b0001, 4'b1001, 4'b0010, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp("shl_2",       4'b1011, 4'b0010, 4'b0110, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1);
    runOp("shr_1",       4'b1011, 4'b0001, 4'b0111, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0);
    runOp("shl_big",     4'b1011, 4'b0100, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    runOp("shl_zero",    4'b1011, 4'b0000, 4'b0110, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_MULDIV_EN
    runOp("mul",         4'b0101, 4'b0011, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    runOp("div_zero",    4'b0111, 4'b0000, 4'b1001, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    runOp("mod",         4'b0111, 4'b0010, 4'b1010, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    runOp("muldiv_off",  4'b0101, 4'b0011, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    runOp("reserved",    4'b0101, 4'b0011, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

    runOp("pre_reset",   4'b1010, 4'b1010, 4'b0010, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 4'b0010, 4'b0000);
    #2 rst = 1'b1;
    #1 checkOutput("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 checkOutput("rst_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("rst_release", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] ra, rb, rs;
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15));
      applyStimulus(ra, rb, rs);
      if ($urandom_range(0, 31) == 0) begin
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end

    @(negedge clk);
    @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
